// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one-outstanding requests on a
// req/gnt/rvalid instruction bus and presents returned instructions to IF/ID.
module fetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            ibus_req_o,
    output logic [XLEN-1:0] ibus_addr_o,
    input  logic            ibus_gnt_i,
    input  logic            ibus_rvalid_i,
    input  logic [XLEN-1:0] ibus_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output logic            inst_valid_o,
    output logic            fetch_stall_o
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_VALID
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] redirect;

    assign redirect      = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign ibus_addr_o   = pc_q;
    assign ibus_req_o    = (state == S_REQ);
    assign fetch_stall_o = ~inst_valid_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_BOOT;
            pc_q         <= RESET_PC;
            pc_o         <= RESET_PC;
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    if (flush_i) pc_q <= redirect;
                    state <= S_REQ;
                end
                S_REQ: begin
                    // Address may move while ungranted; slave samples only on gnt.
                    if (flush_i) pc_q <= redirect;
                    if (ibus_gnt_i) state <= flush_i ? S_DROP : S_WAIT;
                end
                S_WAIT: begin
                    if (flush_i) begin
                        pc_q  <= redirect;
                        state <= ibus_rvalid_i ? S_REQ : S_DROP;
                    end else if (ibus_rvalid_i) begin
                        inst_o       <= ibus_rdata_i;
                        pc_o         <= pc_q;
                        inst_valid_o <= 1'b1;
                        state        <= S_VALID;
                    end
                end
                S_DROP: begin
                    // The dropped response retires the outstanding request even
                    // if a new flush lands in the same cycle.
                    if (flush_i) pc_q <= redirect;
                    if (ibus_rvalid_i) state <= S_REQ;
                end
                S_VALID: begin
                    if (flush_i) begin
                        pc_q         <= redirect;
                        inst_valid_o <= 1'b0;
                        inst_o       <= NOP_INST;
                        state        <= S_REQ;
                    end else if (!stall_i) begin
                        pc_q         <= pc_q + XLEN'(4);
                        inst_valid_o <= 1'b0;
                        inst_o       <= NOP_INST;
                        state        <= S_REQ;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed per-cycle vector bench for fetch_ctrl plus hand sequences for
// PC wrap and asynchronous reset mid-transaction.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, gnt, rvalid;
    logic [31:0] redir, rdata;
    logic        req, inst_valid, fstall;
    logic [31:0] addr, pc, inst;

    fetch_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
        .redirect_pc_i(redir), .ibus_req_o(req), .ibus_addr_o(addr),
        .ibus_gnt_i(gnt), .ibus_rvalid_i(rvalid), .ibus_rdata_i(rdata),
        .pc_o(pc), .inst_o(inst), .inst_valid_o(inst_valid),
        .fetch_stall_o(fstall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, gnt, rvalid;
        logic [31:0] redir, rdata;
        logic        req, valid;
        logic [31:0] addr, pc, inst;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Inputs applied during the cycle, then outputs expected during that same cycle.
    task automatic add(input logic s, input logic f, input logic [31:0] rd,
                       input logic g, input logic rv, input logic [31:0] dat,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_vld, input logic [31:0] e_pc,
                       input logic [31:0] e_inst);
        vec_t v;
        v.stall = s; v.flush = f; v.redir = rd; v.gnt = g; v.rvalid = rv;
        v.rdata = dat; v.req = e_req; v.addr = e_addr; v.valid = e_vld;
        v.pc = e_pc; v.inst = e_inst;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vld, input logic [31:0] e_pc,
                           input logic [31:0] e_inst);
        chk({tag, " req"},   32'(req),        32'(e_req));
        chk({tag, " addr"},  addr,            e_addr);
        chk({tag, " valid"}, 32'(inst_valid), 32'(e_vld));
        chk({tag, " fstall"},32'(fstall),     32'(!e_vld));
        chk({tag, " pc"},    pc,              e_pc);
        chk({tag, " inst"},  inst,            e_inst);
    endtask

    task automatic drive(input logic s, input logic f, input logic [31:0] rd,
                         input logic g, input logic rv, input logic [31:0] dat);
        stall = s; flush = f; redir = rd; gnt = g; rvalid = rv; rdata = dat;
    endtask

    initial begin
        //   stall flush redir  gnt rv rdata            req addr  vld pc   inst
        // boot, zero-wait bus returning addr as data
        add(0, 0, 0,          0, 0, 0,             0, 32'h0,  0, 0,     NOP);   // 0 BOOT
        add(0, 0, 0,          1, 0, 0,             1, 32'h0,  0, 0,     NOP);   // 1 REQ
        add(0, 0, 0,          0, 1, 32'h0,         0, 32'h0,  0, 0,     NOP);   // 2 WAIT
        add(0, 0, 0,          0, 0, 0,             0, 32'h0,  1, 0,     32'h0); // 3 VALID
        // wait states: gnt after 2 cycles, rvalid after 3
        add(0, 0, 0,          0, 0, 0,             1, 32'h4,  0, 0,     NOP);
        add(0, 0, 0,          0, 0, 0,             1, 32'h4,  0, 0,     NOP);
        add(0, 0, 0,          1, 0, 0,             1, 32'h4,  0, 0,     NOP);
        add(0, 0, 0,          0, 0, 0,             0, 32'h4,  0, 0,     NOP);
        add(0, 0, 0,          0, 0, 0,             0, 32'h4,  0, 0,     NOP);
        add(0, 0, 0,          0, 1, 32'h4,         0, 32'h4,  0, 0,     NOP);
        add(0, 0, 0,          0, 0, 0,             0, 32'h4,  1, 32'h4, 32'h4); // 10
        // ungranted flush in REQ moves the address to 0x10
        add(0, 1, 32'h10,     0, 0, 0,             1, 32'h8,  0, 32'h4, NOP);
        add(0, 0, 0,          1, 0, 0,             1, 32'h10, 0, 32'h4, NOP);
        add(0, 0, 0,          0, 1, 32'hDEADBEEF,  0, 32'h10, 0, 32'h4, NOP);
        // stall hold for 5 cycles, stray rvalid ignored
        add(1, 0, 0,          0, 0, 0,             0, 32'h10, 1, 32'h10, 32'hDEADBEEF);
        add(1, 0, 0,          0, 1, 32'h1111,      0, 32'h10, 1, 32'h10, 32'hDEADBEEF);
        add(1, 0, 0,          0, 0, 0,             0, 32'h10, 1, 32'h10, 32'hDEADBEEF);
        add(1, 0, 0,          0, 0, 0,             0, 32'h10, 1, 32'h10, 32'hDEADBEEF);
        add(1, 0, 0,          0, 0, 0,             0, 32'h10, 1, 32'h10, 32'hDEADBEEF);
        add(0, 0, 0,          0, 0, 0,             0, 32'h10, 1, 32'h10, 32'hDEADBEEF);
        add(0, 0, 0,          1, 0, 0,             1, 32'h14, 0, 32'h10, NOP);  // 20
        // flush in WAIT -> DROP, stale rvalid discarded
        add(0, 1, 32'h100,    0, 0, 0,             0, 32'h14, 0, 32'h10, NOP);
        add(0, 0, 0,          0, 1, 32'hBAD,       0, 32'h100,0, 32'h10, NOP);
        add(0, 0, 0,          1, 0, 0,             1, 32'h100,0, 32'h10, NOP);
        add(0, 0, 0,          0, 1, 32'h100,       0, 32'h100,0, 32'h10, NOP);
        // flush+stall in VALID, redirect 0x203 fetched as 0x200
        add(1, 1, 32'h203,    0, 0, 0,             0, 32'h100,1, 32'h100, 32'h100);
        add(0, 0, 0,          1, 0, 0,             1, 32'h200,0, 32'h100, NOP);
        // flush+rvalid in WAIT drops data
        add(0, 1, 32'h300,    0, 1, 32'h999,       0, 32'h200,0, 32'h100, NOP);
        // flush+gnt in REQ -> DROP
        add(0, 1, 32'h400,    1, 0, 0,             1, 32'h300,0, 32'h100, NOP);
        add(0, 0, 0,          0, 1, 32'h777,       0, 32'h400,0, 32'h100, NOP);
        add(0, 0, 0,          0, 0, 0,             1, 32'h400,0, 32'h100, NOP);  // 30

        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            chk_all($sformatf("v%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid,
                    tbl[i].pc, tbl[i].inst);
            drive(tbl[i].stall, tbl[i].flush, tbl[i].redir, tbl[i].gnt,
                  tbl[i].rvalid, tbl[i].rdata);
            @(negedge clk);
        end

        // PC wrap: redirect to 0xFFFF_FFFC, consume, next address is 0
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0); @(negedge clk);
        chk("wrap addr", addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, 0, 0);              @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'hCAFE_F00D);  @(negedge clk);
        chk_all("wrap valid", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D);
        drive(0, 0, 0, 0, 0, 0);              @(negedge clk);
        chk_all("wrap next", 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, NOP);

        // Into WAIT at a nonzero address, then async reset between edges
        drive(0, 1, 32'h40, 0, 0, 0);         @(negedge clk);
        drive(0, 0, 0, 1, 0, 0);              @(negedge clk);
        chk("pre-rst req", 32'(req), 32'd0);
        chk("pre-rst addr", addr, 32'h40);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all("async rst", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        @(negedge clk);
        rst_n = 1'b1;
        chk_all("rst hold", 1'b0, 32'h0, 1'b0, 32'h0, NOP);
        @(negedge clk);
        chk("post-rst req", 32'(req), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
